log_ram_reader: RTL and testbench
=================================

// Module: log_ram_reader
// PURPOSE
//   Read-side datapath of the FIR log memory. Driven by the ram_fsm counter controls (o_rst_cnt/o_en_cnt),
//   walks NUM_WORDS log RAM addresses circularly from a start pointer and issues 1-cycle-latency RAM reads.
//   Streams the words out on a valid/ready interface and returns a run-complete pulse to ram_fsm (i_run_complete).
// PARAMETERS
//   ADDR_W     10    RAM address width
//   DATA_W     16    log word width
//   NUM_WORDS  1024  words per run; 2 <= NUM_WORDS <= 2**ADDR_W; addresses wrap at NUM_WORDS-1 -> 0
// PORTS
//   clock           in   1       system clock, all logic on rising edge
//   i_reset         in   1       asynchronous active-low reset (0 = reset)
//   i_rst_cnt       in   1       synchronous clear from ram_fsm (standby)
//   i_en_cnt        in   1       read-enable from ram_fsm (read state)
//   i_start_addr    in   ADDR_W  first address of the run (log write pointer), < NUM_WORDS
//   o_rd_en         out  1       RAM read strobe
//   o_rd_addr       out  ADDR_W  RAM read address
//   i_rd_data       in   DATA_W  RAM data, valid exactly 1 cycle after o_rd_en
//   o_data          out  DATA_W  streamed log word
//   o_valid         out  1       o_data valid
//   i_ready         in   1       consumer ready; transfer when o_valid & i_ready
//   o_run_complete  out  1       1-cycle pulse after the NUM_WORDS-th transfer
//   o_busy          out  1       1 in FETCH or DRAIN
// BEHAVIOUR
//   - Async reset: state IDLE, counters 0, buffer empty; o_rd_en=0, o_rd_addr=0, o_valid=0, o_data=0,
//     o_run_complete=0, o_busy=0.
//   - i_rst_cnt=1: same clear, synchronous; priority over i_en_cnt. In-flight read data is discarded.
//   - States: IDLE -(i_en_cnt & !i_rst_cnt)-> FETCH: latch i_start_addr, issue count=0.
//     FETCH -(NUM_WORDS reads issued)-> DRAIN -(NUM_WORDS transfers)-> DONE (o_run_complete=1 for that one cycle)
//     -> HOLD. HOLD idles until i_rst_cnt.
//   - Issue rule (FETCH): o_rd_en=1 iff i_en_cnt=1 and (buffer count + in-flight) < 2; back-to-back reads
//     allowed, sustaining 1 word/cycle when i_ready stays high.
//   - Address: o_rd_addr = start, start+1, ...; after NUM_WORDS-1 next is 0; exactly NUM_WORDS reads/run.
//   - Read data is captured into a 2-entry FIFO one cycle after o_rd_en; o_data/o_valid driven from FIFO head
//     (registered). First o_valid is 2 cycles after the first o_rd_en.
//   - i_en_cnt low mid-FETCH: issuing pauses, address holds, in-flight data still captured, output keeps draining.
//   - i_ready low: o_valid/o_data held stable until transfer; the credit rule guarantees no overflow.
//   - Counters are $clog2(NUM_WORDS+1) bits; no wrap of the issue/transfer counters within a run.
// CONFIGURATION
//   LOG_RD_CHKSUM_EN defined: extra port o_chksum (out, DATA_W) = modulo-2**DATA_W sum of all transferred
//     words; cleared on reset/i_rst_cnt; final and stable from the o_run_complete cycle until next clear.
//   Not defined: no o_chksum port and no accumulator logic; all other behaviour identical.
// STRUCTURE
//   log_mem_pkg: state enum (IDLE, FETCH, DRAIN, DONE, HOLD), RAM read latency constant (=1),
//     FIFO depth constant (=2).
//   Sub-module log_rd_fifo: 2-entry synchronous FIFO (push/pop/flush, count, head data).
//   Top: FSM, address/issue/transfer counters, in-flight flag, checksum.
// TESTING
//   1 NUM_WORDS=8, start=0, i_ready=1: words 0..7 out in order on 8 consecutive cycles; o_run_complete
//     1 cycle after the last transfer.
//   2 start=5, NUM_WORDS=8: addresses 5,6,7,0,1,2,3,4; exactly 8 o_rd_en pulses.
//   3 i_ready toggled 1/0 randomly: no word lost or duplicated; o_data stable while o_valid & !i_ready.
//   4 i_en_cnt dropped for 3 cycles after 3 reads: no o_rd_en, o_rd_addr holds; run resumes, completes with 8 words.
//   5 i_rst_cnt asserted mid-run (after 4 transfers): next cycle o_valid=0, o_busy=0; a new run restarts
//     from i_start_addr.
//   6 async i_reset low mid-run: all outputs 0 immediately; with LOG_RD_CHKSUM_EN, words 1..8 give
//     o_chksum=36 at completion.

Source files
------------

// File: rtl/log_mem_pkg.sv
// Shared types and constants for the FIR log memory read path.
// Contents: read-side state enum, RAM read latency, output FIFO depth/count width.
package log_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4
    } rd_state_e;

    // RAM data arrives this many cycles after the read strobe
    localparam int unsigned RD_LATENCY = 1;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/log_rd_fifo.sv
// Two-entry shift FIFO holding captured log words; the head entry is a flop so
// the streamed word and its valid bit leave the block straight from registers.
// Ports:
//   clock, i_reset   clock / async active-low reset
//   i_flush          synchronous clear of all entries
//   i_push, i_data   write a word (never while full without a pop)
//   i_pop            remove the head word
//   o_data, o_valid  head word and its valid flag (registered)
//   o_count_c        number of stored words (combinational decode)
module log_rd_fifo
    import log_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_W-1:0]     i_data,
    output logic [DATA_W-1:0]     o_data,
    output logic                  o_valid,
    output logic [FIFO_CNT_W-1:0] o_count_c
);

    logic [DATA_W-1:0] tail_q;
    logic              tail_vld_q;
    logic              pop_c;

    assign pop_c     = i_pop & o_valid;
    assign o_count_c = FIFO_CNT_W'(o_valid) + FIFO_CNT_W'(tail_vld_q);

    // Entry 0 is the head; a pop shifts entry 1 forward
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_data     <= '0;
            o_valid    <= 1'b0;
            tail_q     <= '0;
            tail_vld_q <= 1'b0;
        end else if (i_flush) begin
            o_data     <= '0;
            o_valid    <= 1'b0;
            tail_q     <= '0;
            tail_vld_q <= 1'b0;
        end else begin
            case ({i_push, pop_c})
                2'b10: begin
                    if (!o_valid) begin
                        o_data  <= i_data;
                        o_valid <= 1'b1;
                    end else begin
                        tail_q     <= i_data;
                        tail_vld_q <= 1'b1;
                    end
                end
                2'b01: begin
                    o_data     <= tail_q;
                    o_valid    <= tail_vld_q;
                    tail_q     <= '0;
                    tail_vld_q <= 1'b0;
                end
                2'b11: begin
                    if (tail_vld_q) begin
                        o_data <= tail_q;
                        tail_q <= i_data;
                    end else begin
                        o_data <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/log_ram_reader.sv
// Read-side datapath of the FIR log memory. Walks NUM_WORDS addresses circularly
// from a start pointer, issues 1-cycle-latency RAM reads under a 2-word credit,
// streams words on valid/ready and pulses o_run_complete after the last transfer.
// Ports:
//   clock, i_reset            clock / async active-low reset
//   i_rst_cnt, i_en_cnt       clear / read enable from ram_fsm
//   i_start_addr              first address of a run
//   o_rd_en, o_rd_addr        RAM read strobe and address
//   i_rd_data                 RAM data, one cycle after o_rd_en
//   o_data, o_valid, i_ready  streamed log word handshake
//   o_run_complete, o_busy    run status
//   o_chksum                  only with LOG_RD_CHKSUM_EN: sum of transferred words
// Optional feature macro: LOG_RD_CHKSUM_EN
module log_ram_reader
    import log_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_WORDS = 1024
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_rst_cnt,
    input  logic              i_en_cnt,
    input  logic [ADDR_W-1:0] i_start_addr,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_run_complete,
    output logic              o_busy
`ifdef LOG_RD_CHKSUM_EN
    ,
    output logic [DATA_W-1:0] o_chksum
`endif
);

    localparam int unsigned       CNT_W     = $clog2(NUM_WORDS + 1);
    localparam int unsigned       OCC_W     = FIFO_CNT_W + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    rd_state_e             state_q;
    logic [CNT_W-1:0]      issue_cnt_q;
    logic [CNT_W-1:0]      xfer_cnt_q;
    logic                  inflight_q;
    logic [FIFO_CNT_W-1:0] fifo_cnt_c;
    logic [OCC_W-1:0]      occ_c;
    logic                  xfer_c;
    logic                  rd_en_c;

    assign xfer_c = o_valid & i_ready & ~i_rst_cnt;

    // Words that will sit in the FIFO after this edge, counting the read now in flight
    assign occ_c = OCC_W'(fifo_cnt_c) + OCC_W'(inflight_q) - OCC_W'(xfer_c);

    // Read strobe follows i_en_cnt in the same cycle so a pause stops issue at once
    assign rd_en_c = (state_q == ST_FETCH) & i_en_cnt & ~i_rst_cnt
                   & (occ_c < OCC_W'(FIFO_DEPTH));
    assign o_rd_en = rd_en_c;

    // Run FSM, address walk, counters and status outputs
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q        <= ST_IDLE;
            o_rd_addr      <= '0;
            issue_cnt_q    <= '0;
            xfer_cnt_q     <= '0;
            inflight_q     <= 1'b0;
            o_run_complete <= 1'b0;
            o_busy         <= 1'b0;
        end else if (i_rst_cnt) begin
            state_q        <= ST_IDLE;
            o_rd_addr      <= '0;
            issue_cnt_q    <= '0;
            xfer_cnt_q     <= '0;
            inflight_q     <= 1'b0;
            o_run_complete <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            inflight_q     <= rd_en_c;
            o_run_complete <= 1'b0;
            if (rd_en_c) begin
                issue_cnt_q <= issue_cnt_q + 1'b1;
                o_rd_addr   <= (o_rd_addr == LAST_ADDR) ? '0 : o_rd_addr + 1'b1;
            end
            if (xfer_c) begin
                xfer_cnt_q <= xfer_cnt_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_en_cnt) begin
                        state_q     <= ST_FETCH;
                        o_rd_addr   <= i_start_addr;
                        issue_cnt_q <= '0;
                        xfer_cnt_q  <= '0;
                        o_busy      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (rd_en_c && (issue_cnt_q == LAST_CNT)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (xfer_c && (xfer_cnt_q == LAST_CNT)) begin
                        state_q        <= ST_DONE;
                        o_run_complete <= 1'b1;
                        o_busy         <= 1'b0;
                    end
                end
                ST_DONE: state_q <= ST_HOLD;
                ST_HOLD: state_q <= ST_HOLD;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    log_rd_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_flush   (i_rst_cnt),
        .i_push    (inflight_q),
        .i_pop     (xfer_c),
        .i_data    (i_rd_data),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_count_c (fifo_cnt_c)
    );

`ifdef LOG_RD_CHKSUM_EN
    // Running modulo sum of transferred words; final in the o_run_complete cycle
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_chksum <= '0;
        end else if (i_rst_cnt) begin
            o_chksum <= '0;
        end else if (xfer_c) begin
            o_chksum <= o_chksum + o_data;
        end
    end
`endif

endmodule

// File: tb/tb_log_ram_reader.sv
// Bench for log_ram_reader: RAM model returns addr+1, scoreboard queues hold the
// expected read addresses and streamed words, a negedge monitor pops and compares.
module tb_log_ram_reader;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned NUM_WORDS = 8;

    logic              clock = 1'b0;
    logic              i_reset;
    logic              i_rst_cnt;
    logic              i_en_cnt;
    logic [ADDR_W-1:0] i_start_addr;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [DATA_W-1:0] i_rd_data = '0;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_run_complete;
    logic              o_busy;
`ifdef LOG_RD_CHKSUM_EN
    logic [DATA_W-1:0] o_chksum;
`endif

    always #5 clock = ~clock;

    log_ram_reader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clock          (clock),
        .i_reset        (i_reset),
        .i_rst_cnt      (i_rst_cnt),
        .i_en_cnt       (i_en_cnt),
        .i_start_addr   (i_start_addr),
        .o_rd_en        (o_rd_en),
        .o_rd_addr      (o_rd_addr),
        .i_rd_data      (i_rd_data),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_run_complete (o_run_complete),
        .o_busy         (o_busy)
`ifdef LOG_RD_CHKSUM_EN
        ,
        .o_chksum       (o_chksum)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    int                rd_cyc[$];
    int                xfer_cyc[$];
    int                cyc        = 0;
    int                done_total = 0;
    int                done_cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // RAM model: word at address a is a+1, valid for exactly one cycle
    always @(posedge clock) begin
        if (o_rd_en) i_rd_data <= DATA_W'(32'(o_rd_addr) + 1);
        else         i_rd_data <= 16'hDEAD;
    end

    // Monitor
    initial begin
        logic              done_due;
        logic              hold_pend;
        logic [DATA_W-1:0] hold_data;
        done_due  = 1'b0;
        hold_pend = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (o_rd_en) begin
                rd_cyc.push_back(cyc);
                if (exp_addr_q.size() == 0) chk("rd_unexpected", 32'(o_rd_en), 32'd0);
                else chk("rd_addr", 32'(o_rd_addr), 32'(exp_addr_q.pop_front()));
            end
            if (o_run_complete || done_due) chk("run_complete", 32'(o_run_complete), 32'(done_due));
            if (o_run_complete) begin
                done_total++;
                done_cyc = cyc;
            end
            done_due = 1'b0;
            if (hold_pend && i_reset) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_data", 32'(o_data), 32'(hold_data));
            end
            if (o_valid && i_ready && !i_rst_cnt && i_reset) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) chk("xfer_unexpected", 32'(o_valid & i_ready), 32'd0);
                else begin
                    chk("xfer_data", 32'(o_data), 32'(exp_q.pop_front()));
                    if (exp_q.size() == 0) done_due = 1'b1;
                end
            end
            hold_pend = o_valid && !i_ready && !i_rst_cnt && i_reset;
            hold_data = o_data;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_run(input int s);
        for (int i = 0; i < int'(NUM_WORDS); i++) begin
            int a;
            a = (s + i) % int'(NUM_WORDS);
            exp_addr_q.push_back(ADDR_W'(a));
            exp_q.push_back(DATA_W'(a + 1));
        end
        i_start_addr = ADDR_W'(s);
        i_en_cnt     = 1'b1;
    endtask

    task automatic wait_done(input string name, input logic [15:0] pat);
        int d0;
        int n;
        d0 = done_total;
        n  = 0;
        while (done_total == d0 && n < 400) begin
            i_ready = pat[n % 16];
            tick();
            n++;
        end
        i_ready = 1'b1;
        chk({name, "_done_seen"}, 32'(done_total != d0), 32'd1);
        chk({name, "_addr_q_empty"}, 32'(exp_addr_q.size()), 32'd0);
        chk({name, "_data_q_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_run();
        i_en_cnt  = 1'b0;
        i_rst_cnt = 1'b1;
        tick();
        i_rst_cnt = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_r;
        int a_x;
        int n;
        i_reset      = 1'b0;
        i_rst_cnt    = 1'b0;
        i_en_cnt     = 1'b0;
        i_ready      = 1'b1;
        i_start_addr = '0;
        tick();
        tick();
        chk("rst_rd_en", 32'(o_rd_en), 32'd0);
        chk("rst_rd_addr", 32'(o_rd_addr), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_run_complete", 32'(o_run_complete), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        i_reset = 1'b1;
        tick();

        // 1: start 0, ready always high, timing of the stream
        a_r = rd_cyc.size();
        a_x = xfer_cyc.size();
        start_run(0);
        wait_done("t1", 16'hFFFF);
        chk("t1_reads", 32'(rd_cyc.size() - a_r), 32'd8);
        chk("t1_xfers", 32'(xfer_cyc.size() - a_x), 32'd8);
        if (xfer_cyc.size() >= a_x + 8 && rd_cyc.size() > a_r) begin
            chk("t1_first_valid_lat", 32'(xfer_cyc[a_x] - rd_cyc[a_r]), 32'd2);
            chk("t1_burst_len", 32'(xfer_cyc[a_x + 7] - xfer_cyc[a_x]), 32'd7);
            chk("t1_done_lat", 32'(done_cyc - xfer_cyc[a_x + 7]), 32'd1);
        end
        chk("t1_busy_hold", 32'(o_busy), 32'd0);
`ifdef LOG_RD_CHKSUM_EN
        chk("t1_chksum", 32'(o_chksum), 32'd36);
`endif
        clear_run();

        // 2: start 5, wrap 7 -> 0
        a_r = rd_cyc.size();
        start_run(5);
        wait_done("t2", 16'hFFFF);
        chk("t2_reads", 32'(rd_cyc.size() - a_r), 32'd8);
        clear_run();

        // 3: ready toggled by a fixed pattern
        a_x = xfer_cyc.size();
        start_run(2);
        wait_done("t3", 16'b1011_0010_1100_0101);
        chk("t3_xfers", 32'(xfer_cyc.size() - a_x), 32'd8);
        clear_run();

        // 4: enable dropped for 3 cycles after 3 reads
        a_r = rd_cyc.size();
        start_run(6);
        n = 0;
        while (rd_cyc.size() - a_r < 3 && n < 50) begin
            tick();
            n++;
        end
        chk("t4_three_reads", 32'(rd_cyc.size() - a_r), 32'd3);
        i_en_cnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("t4_pause_rd_en", 32'(o_rd_en), 32'd0);
            chk("t4_pause_addr", 32'(o_rd_addr), 32'd1);
            tick();
        end
        i_en_cnt = 1'b1;
        wait_done("t4", 16'hFFFF);
        chk("t4_reads", 32'(rd_cyc.size() - a_r), 32'd8);
        clear_run();

        // 5: synchronous clear after 4 transfers, then a fresh run
        a_x = xfer_cyc.size();
        start_run(1);
        n = 0;
        while (xfer_cyc.size() - a_x < 4 && n < 50) begin
            tick();
            n++;
        end
        i_ready   = 1'b0;
        i_rst_cnt = 1'b1;
        i_en_cnt  = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        tick();
        i_rst_cnt = 1'b0;
        @(negedge clock);
        chk("t5_valid_cleared", 32'(o_valid), 32'd0);
        chk("t5_busy_cleared", 32'(o_busy), 32'd0);
        chk("t5_xfers", 32'(xfer_cyc.size() - a_x), 32'd4);
        tick();
        i_ready = 1'b1;
        start_run(4);
        wait_done("t5", 16'hFFFF);
        clear_run();

        // 6: async reset mid-run, then a full run for the checksum
        a_x = xfer_cyc.size();
        start_run(3);
        n = 0;
        while (xfer_cyc.size() - a_x < 3 && n < 50) begin
            tick();
            n++;
        end
        #2;
        i_reset = 1'b0;
        #1;
        chk("t6_rd_en", 32'(o_rd_en), 32'd0);
        chk("t6_rd_addr", 32'(o_rd_addr), 32'd0);
        chk("t6_valid", 32'(o_valid), 32'd0);
        chk("t6_data", 32'(o_data), 32'd0);
        chk("t6_run_complete", 32'(o_run_complete), 32'd0);
        chk("t6_busy", 32'(o_busy), 32'd0);
`ifdef LOG_RD_CHKSUM_EN
        chk("t6_chksum_reset", 32'(o_chksum), 32'd0);
`endif
        exp_q.delete();
        exp_addr_q.delete();
        i_en_cnt = 1'b0;
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        start_run(3);
        wait_done("t6", 16'hFFFF);
`ifdef LOG_RD_CHKSUM_EN
        chk("t6_chksum", 32'(o_chksum), 32'd36);
        repeat (3) tick();
        chk("t6_chksum_stable", 32'(o_chksum), 32'd36);
        clear_run();
        chk("t6_chksum_clear", 32'(o_chksum), 32'd0);
`else
        clear_run();
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
